// File: rtl/audio_window_scheduler.sv
// audio_window_scheduler
// Captures every incoming sample into a 2*WINDOW_SIZE circular buffer. The
// first window is scheduled after WINDOW_SIZE samples, then one every HOP_SIZE
// samples. Each window streams oldest-first over valid/ready.
// A trigger that lands mid-stream is dropped and latched in overrun_out.
// Optional build macro AUDIO_WINDOW_SCHED_DROP_COUNT_EN adds a saturating
// 16-bit drop_count_out.
module audio_window_scheduler #(
  parameter int DATA_WIDTH  = 16,
  parameter int WINDOW_SIZE = 2048,
  parameter int HOP_SIZE    = 512
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  output logic                  window_start_out,
  output logic [DATA_WIDTH-1:0] window_data_out,
  output logic                  window_valid_out,
  input  logic                  window_ready_in,
  output logic                  window_last_out,
`ifdef AUDIO_WINDOW_SCHED_DROP_COUNT_EN
  output logic [15:0]           drop_count_out,
`endif
  output logic                  overrun_out
);

  // Buffer address and phase counters share one width. It covers both
  // 2*WINDOW_SIZE addresses and a count of WINDOW_SIZE without wrapping.
  localparam int AW    = $clog2(WINDOW_SIZE) + 1;
  localparam int DEPTH = 2 * WINDOW_SIZE;

  typedef enum logic [1:0] {FILL, WAIT, STREAM} state_t;

  state_t                state;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         fill_cnt;
  logic [AW-1:0]         hop_cnt;
  logic [AW-1:0]         rd_idx;
  logic [AW-1:0]         base_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          fill_hit, hop_hit, trigger, drop, xfer, rd_en;
  logic [AW-1:0] rd_addr, base_next;

  assign fill_hit  = sample_valid_in && (fill_cnt == AW'(WINDOW_SIZE - 1));
  assign hop_hit   = sample_valid_in && (hop_cnt == AW'(HOP_SIZE - 1));
  assign trigger   = ((state == FILL) && fill_hit) || ((state == WAIT) && hop_hit);
  assign drop      = (state == STREAM) && hop_hit;
  assign xfer      = window_valid_out && window_ready_in;
  // Refill the output register whenever it is empty or being drained.
  // This keeps the stream gap-free under a steady ready.
  assign rd_en     = (state == STREAM) && (rd_idx != AW'(WINDOW_SIZE)) &&
                     (!window_valid_out || window_ready_in);
  assign rd_addr   = base_addr + rd_idx;
  // Window ends with the sample being written this cycle (wr_ptr + 1 after write).
  assign base_next = wr_ptr + AW'(1) - AW'(WINDOW_SIZE);

  // Sample buffer write port; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (sample_valid_in) mem[wr_ptr] <= sample_in;
  end

  // Synchronous read port doubles as the output data register (held on stall).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)     window_data_out <= '0;
    else if (rd_en) window_data_out <= mem[rd_addr];
  end

  // Control FSM: capture counting, trigger/drop decisions, stream sequencing.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= FILL;
      wr_ptr           <= '0;
      fill_cnt         <= '0;
      hop_cnt          <= '0;
      rd_idx           <= '0;
      base_addr        <= '0;
      window_start_out <= 1'b0;
      window_valid_out <= 1'b0;
      window_last_out  <= 1'b0;
      overrun_out      <= 1'b0;
`ifdef AUDIO_WINDOW_SCHED_DROP_COUNT_EN
      drop_count_out   <= '0;
`endif
    end else begin
      window_start_out <= 1'b0;
      if (sample_valid_in) wr_ptr <= wr_ptr + AW'(1);

      if (rd_en) begin
        rd_idx           <= rd_idx + AW'(1);
        window_valid_out <= 1'b1;
        window_last_out  <= (rd_idx == AW'(WINDOW_SIZE - 1));
      end else if (xfer) begin
        window_valid_out <= 1'b0;
        window_last_out  <= 1'b0;
      end

      if (trigger) begin
        state            <= STREAM;
        hop_cnt          <= '0;
        rd_idx           <= '0;
        base_addr        <= base_next;
        window_start_out <= 1'b1;
      end

      case (state)
        FILL: begin
          if (sample_valid_in) fill_cnt <= fill_cnt + AW'(1);
        end
        WAIT: begin
          if (sample_valid_in && !hop_hit) hop_cnt <= hop_cnt + AW'(1);
        end
        STREAM: begin
          if (drop) begin
            hop_cnt     <= '0;
            overrun_out <= 1'b1;
`ifdef AUDIO_WINDOW_SCHED_DROP_COUNT_EN
            if (drop_count_out != 16'hFFFF) drop_count_out <= drop_count_out + 16'd1;
`endif
          end else if (sample_valid_in) begin
            hop_cnt <= hop_cnt + AW'(1);
          end
          if (xfer && window_last_out) state <= WAIT;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_window_scheduler.sv
// Testbench for audio_window_scheduler (WINDOW_SIZE=8, HOP_SIZE=4).
// Reference model: a sample history list plus abstract trigger rules.
module tb_audio_window_scheduler;
  localparam int DW = 16;
  localparam int WS = 8;
  localparam int HS = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid_in = 1'b0;
  logic          window_ready_in = 1'b0;
  logic          window_start_out, window_valid_out, window_last_out, overrun_out;
  logic [DW-1:0] window_data_out;
`ifdef AUDIO_WINDOW_SCHED_DROP_COUNT_EN
  logic [15:0]   drop_count_out;
`endif

  always #5 clk_in = ~clk_in;

  audio_window_scheduler #(.DATA_WIDTH(DW), .WINDOW_SIZE(WS), .HOP_SIZE(HS)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .window_start_out (window_start_out),
    .window_data_out  (window_data_out),
    .window_valid_out (window_valid_out),
    .window_ready_in  (window_ready_in),
    .window_last_out  (window_last_out),
`ifdef AUDIO_WINDOW_SCHED_DROP_COUNT_EN
    .drop_count_out   (drop_count_out),
`endif
    .overrun_out      (overrun_out)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [DW-1:0] hist[$];
  logic [DW-1:0] win[WS];
  int  n_samp, hop, xidx, since_trig, starts, xfers, drops_exp, rdy_mode, cyc;
  bit  filled, busy, start_due, seen_valid, ovr_exp, prev_hold, prev_last;
  logic [DW-1:0] prev_data;

  task automatic model_reset();
    hist.delete();
    n_samp = 0; hop = 0; xidx = 0; since_trig = 0; starts = 0; xfers = 0;
    drops_exp = 0; filled = 0; busy = 0; start_due = 0; seen_valid = 0;
    ovr_exp = 0; prev_hold = 0; prev_last = 0; prev_data = '0;
  endtask

  task automatic model_trigger();
    for (int i = 0; i < WS; i++) win[i] = hist[hist.size() - WS + i];
    busy = 1; start_due = 1; xidx = 0; since_trig = 0; seen_valid = 0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic v, input logic [DW-1:0] d);
    logic rdy, xfer, allowed;
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = (cyc % 4 == 0);
      2:       rdy = 1'b0;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    sample_valid_in = v; sample_in = d; window_ready_in = rdy;
    @(negedge clk_in);
    since_trig++;

    vectors++;
    if (window_start_out !== start_due) begin
      miscompares++;
      $display("FAIL start: got %b want %b (cycle %0d)", window_start_out, start_due, cyc);
    end
    if (window_start_out === 1'b1) starts++;
    start_due = 0;

    vectors++;
    if (overrun_out !== ovr_exp) begin
      miscompares++;
      $display("FAIL overrun: got %b want %b (cycle %0d)", overrun_out, ovr_exp, cyc);
    end
`ifdef AUDIO_WINDOW_SCHED_DROP_COUNT_EN
    vectors++;
    if (drop_count_out !== 16'(drops_exp)) begin
      miscompares++;
      $display("FAIL drop_count: got %0d want %0d", drop_count_out, drops_exp);
    end
`endif

    if (prev_hold) begin
      vectors++;
      if ({window_valid_out, window_last_out, window_data_out} !== {1'b1, prev_last, prev_data}) begin
        miscompares++;
        $display("FAIL stall_hold: got v%b l%b %0h want v1 l%b %0h",
                 window_valid_out, window_last_out, window_data_out, prev_last, prev_data);
      end
    end

    allowed = busy && (xidx < WS);
    vectors++;
    if (window_valid_out === 1'b1 && !allowed) begin
      miscompares++;
      $display("FAIL spurious_valid: got valid=1 data %0h want valid=0", window_data_out);
    end
    if (allowed && window_valid_out === 1'b1) begin
      seen_valid = 1;
      vectors++;
      if ({window_last_out, window_data_out} !== {(xidx == WS - 1), win[xidx]}) begin
        miscompares++;
        $display("FAIL data[%0d]: got l%b %0h want l%b %0h", xidx,
                 window_last_out, window_data_out, (xidx == WS - 1), win[xidx]);
      end
    end else if (busy && !seen_valid && since_trig >= 2) begin
      vectors++; miscompares++; seen_valid = 1;
      $display("FAIL first_valid_latency: got valid=%b want 1 at trigger+2", window_valid_out);
    end

    xfer = (window_valid_out === 1'b1) && rdy && allowed;

    // Sample arrival; a sample in the final transfer cycle still counts as mid-stream.
    if (v) begin
      hist.push_back(d); n_samp++;
      if (!filled) begin
        if (n_samp == WS) begin filled = 1; model_trigger(); end
      end else begin
        hop++;
        if (hop == HS) begin
          hop = 0;
          if (busy) begin ovr_exp = 1; if (drops_exp < 65535) drops_exp++; end
          else model_trigger();
        end
      end
    end
    if (xfer) begin
      xfers++; xidx++;
      if (xidx == WS) busy = 0;
    end

    prev_hold = (window_valid_out === 1'b1) && !rdy;
    prev_last = window_last_out; prev_data = window_data_out;
    cyc++;
    @(posedge clk_in); #1;
  endtask

  task automatic feed(input int first, input int count, input int period);
    for (int k = 0; k < count; k++) begin
      step(1'b1, DW'(first + k));
      for (int j = 1; j < period; j++) step(1'b0, '0);
    end
  endtask

  task automatic drain(input int limit);
    int i = 0;
    while (busy && i < limit) begin step(1'b0, '0); i++; end
    vectors++;
    if (busy) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d of %0d transfers after %0d cycles", xidx, WS, limit);
    end
    for (int j = 0; j < 3; j++) step(1'b0, '0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1; sample_valid_in = 1'b0; window_ready_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic check_count(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({window_start_out, window_valid_out, window_last_out, overrun_out, window_data_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got s%b v%b l%b o%b d%0h want all 0", window_start_out,
               window_valid_out, window_last_out, overrun_out, window_data_out);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    rdy_mode = 0;
    feed(1, 8, 10);
    drain(50);
    check_count("fill_starts", starts, 1);
    check_count("fill_xfers", xfers, 8);
  endtask

  task automatic test_hop();
    feed(9, 4, 10);
    drain(50);
    check_count("hop_starts", starts, 2);
    check_count("hop_xfers", xfers, 16);
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_mode = 1;
    feed(1, 8, 10);
    drain(100);
    check_count("bp_xfers", xfers, 8);
  endtask

  task automatic test_overrun();
    do_reset();
    rdy_mode = 2;
    feed(1, 12, 10);
    vectors++;
    if (overrun_out !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_set: got %b want 1", overrun_out);
    end
    rdy_mode = 0;
    drain(50);
    feed(13, 4, 10);
    drain(50);
    check_count("ovr_starts", starts, 2);
    check_count("ovr_xfers", xfers, 16);
`ifdef AUDIO_WINDOW_SCHED_DROP_COUNT_EN
    check_count("ovr_drop_count", int'(drop_count_out), 1);
`endif
  endtask

  // Samples every 3rd cycle with ready high: writes collide with transfers,
  // but each hop still outlasts a full stream, so nothing is dropped.
  task automatic test_concurrent();
    do_reset();
    rdy_mode = 0;
    feed(1, 16, 3);
    drain(50);
    check_count("conc_starts", starts, 3);
    check_count("conc_xfers", xfers, 24);
    check_count("conc_overrun", int'(overrun_out), 0);
  endtask

  task automatic test_random();
    do_reset();
    rdy_mode = 3;
    for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 2) == 0), DW'($urandom));
    drain(500);
  endtask

  task automatic test_reset_mid();
    int i = 0;
    do_reset();
    rdy_mode = 0;
    feed(1, 8, 1);
    while (xfers < 3 && i < 20) begin step(1'b0, '0); i++; end
    check_count("mid_xfers_before_reset", xfers, 3);
    rst_in = 1'b1;
    #1;
    vectors++;
    if ({window_start_out, window_valid_out, window_last_out, overrun_out, window_data_out} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got s%b v%b l%b o%b d%0h want all 0", window_start_out,
               window_valid_out, window_last_out, overrun_out, window_data_out);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    model_reset();
    feed(100, 8, 10);
    drain(50);
    check_count("mid_restart_starts", starts, 1);
    check_count("mid_restart_xfers", xfers, 8);
  endtask

  initial begin
    cyc = 0; rdy_mode = 0;
    model_reset();
    test_reset();
    test_fill();
    test_hop();
    test_backpressure();
    test_overrun();
    test_concurrent();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
